evt_stream_buffer: RTL and testbench

Elastic event FIFO placed directly downstream of each source port of the event crossbar. It decouples a crossbar output stream from the consuming engine so that short consumer stalls do not propagate back through the crossbar and hold every attached destination. It has registered storage, a synchronous flush and occupancy flags. Optional per-port traffic counters can be compiled in.

---
 rtl/evt_stream_buffer_if.sv | 12 +
 rtl/evt_stream_buffer.sv | 145 ++++++++++++++
 tb/tb_evt_stream_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evt_stream_buffer_if.sv
// Event stream handshake bundle carrying one payload of type T per transfer.
// The src side drives evt/valid, the dst side drives ready.
interface SNE_EVENT_STREAM #(
  parameter type T = logic
);
  T     evt;
  logic valid;
  logic ready;

  modport src (output evt, output valid, input ready);
  modport dst (input evt, input valid, output ready);
endinterface

// File: rtl/evt_stream_buffer.sv
// evt_stream_buffer: elastic event FIFO that sits behind a crossbar source
// port, so that short consumer stalls are absorbed locally instead of
// backing up the crossbar.
// Optional traffic counters are compiled in with EVT_STREAM_BUFFER_STATS_EN;
// without it, count_in_o/count_out_o are tied to zero and clear_stats_i is
// ignored.
module evt_stream_buffer #(
  parameter type T = logic,
  parameter int DEPTH = 4,
  localparam int FILL_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  clear_stats_i,
  SNE_EVENT_STREAM.dst          evt_stream_dst,
  SNE_EVENT_STREAM.src          evt_stream_src,
  output logic [FILL_WIDTH-1:0] fill_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [31:0]           count_in_o,
  output logic [31:0]           count_out_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [FILL_WIDTH-1:0] FULL_FILL = FILL_WIDTH'(DEPTH);

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FILL_WIDTH-1:0] fill_q, fill_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Handshake qualifiers: ready looks only at registered occupancy, flush and
  // reset, so a full buffer never accepts into the slot being popped.
  always_comb begin
    full_o    = (fill_q == FULL_FILL);
    empty_o   = (fill_q == '0);
    fill_o    = fill_q;
    in_ready  = !full_o && !flush_i && !rst_i;
    out_valid = !empty_o && !flush_i;
    push      = evt_stream_dst.valid && in_ready;
    pop       = out_valid && evt_stream_src.ready;
  end

  assign evt_stream_dst.ready = in_ready;
  assign evt_stream_src.valid = out_valid;
  assign evt_stream_src.evt   = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap at DEPTH-1 by compare so that
  // non-power-of-two depths work, and flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill_d = fill_q + FILL_WIDTH'(1);
        2'b01:   fill_d = fill_q - FILL_WIDTH'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Storage write: the accepted event lands at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = evt_stream_dst.evt;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Payload storage needs no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef EVT_STREAM_BUFFER_STATS_EN
  logic [31:0] count_in_q, count_in_d;
  logic [31:0] count_out_q, count_out_d;

  // Traffic counters; a clear in the same cycle as a handshake wins.
  always_comb begin
    count_in_d  = count_in_q;
    count_out_d = count_out_q;
    if (clear_stats_i) begin
      count_in_d  = '0;
      count_out_d = '0;
    end else begin
      if (push) count_in_d = count_in_q + 32'd1;
      if (pop)  count_out_d = count_out_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset but not by flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_in_q  <= '0;
      count_out_q <= '0;
    end else begin
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
    end
  end

  assign count_in_o  = count_in_q;
  assign count_out_o = count_out_q;
`else
  logic unused_clear_stats;

  assign unused_clear_stats = clear_stats_i;
  assign count_in_o         = 32'd0;
  assign count_out_o        = 32'd0;
`endif

endmodule

// File: tb/tb_evt_stream_buffer.sv
// Self-checking bench for evt_stream_buffer: a DEPTH=4 and a DEPTH=3
// instance, each compared every cycle against a queue-based reference model,
// plus a directed vector table and hand-written corner-case sequences.
module tb_evt_stream_buffer;

  typedef logic [7:0] evt_t;

`ifdef EVT_STREAM_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst       [2];
  logic flush     [2];
  logic clr       [2];
  logic in_valid  [2];
  evt_t in_evt    [2];
  logic out_ready [2];

  logic        o_ready [2];
  logic        o_valid [2];
  evt_t        o_evt   [2];
  logic [7:0]  o_fill  [2];
  logic        o_full  [2];
  logic        o_empty [2];
  logic [31:0] o_cin   [2];
  logic [31:0] o_cout  [2];

  SNE_EVENT_STREAM #(.T(evt_t)) in_if0 ();
  SNE_EVENT_STREAM #(.T(evt_t)) out_if0 ();
  SNE_EVENT_STREAM #(.T(evt_t)) in_if1 ();
  SNE_EVENT_STREAM #(.T(evt_t)) out_if1 ();

  logic [2:0]  fill_w0;
  logic [1:0]  fill_w1;
  logic        full_w0, full_w1, empty_w0, empty_w1;
  logic [31:0] cin_w0, cin_w1, cout_w0, cout_w1;

  assign in_if0.valid  = in_valid[0];
  assign in_if0.evt    = in_evt[0];
  assign out_if0.ready = out_ready[0];
  assign in_if1.valid  = in_valid[1];
  assign in_if1.evt    = in_evt[1];
  assign out_if1.ready = out_ready[1];

  assign o_ready[0] = in_if0.ready;
  assign o_valid[0] = out_if0.valid;
  assign o_evt[0]   = out_if0.evt;
  assign o_fill[0]  = {5'd0, fill_w0};
  assign o_full[0]  = full_w0;
  assign o_empty[0] = empty_w0;
  assign o_cin[0]   = cin_w0;
  assign o_cout[0]  = cout_w0;
  assign o_ready[1] = in_if1.ready;
  assign o_valid[1] = out_if1.valid;
  assign o_evt[1]   = out_if1.evt;
  assign o_fill[1]  = {6'd0, fill_w1};
  assign o_full[1]  = full_w1;
  assign o_empty[1] = empty_w1;
  assign o_cin[1]   = cin_w1;
  assign o_cout[1]  = cout_w1;

  evt_stream_buffer #(.T(evt_t), .DEPTH(4)) u_dut4 (
    .clk_i          (clk),
    .rst_i          (rst[0]),
    .flush_i        (flush[0]),
    .clear_stats_i  (clr[0]),
    .evt_stream_dst (in_if0),
    .evt_stream_src (out_if0),
    .fill_o         (fill_w0),
    .full_o         (full_w0),
    .empty_o        (empty_w0),
    .count_in_o     (cin_w0),
    .count_out_o    (cout_w0)
  );

  evt_stream_buffer #(.T(evt_t), .DEPTH(3)) u_dut3 (
    .clk_i          (clk),
    .rst_i          (rst[1]),
    .flush_i        (flush[1]),
    .clear_stats_i  (clr[1]),
    .evt_stream_dst (in_if1),
    .evt_stream_src (out_if1),
    .fill_o         (fill_w1),
    .full_o         (full_w1),
    .empty_o        (empty_w1),
    .count_in_o     (cin_w1),
    .count_out_o    (cout_w1)
  );

  // Reference model: a plain queue of stored events plus handshake tallies.
  int          depth [2] = '{4, 3};
  evt_t        mq    [2][$];
  logic [31:0] mcin  [2];
  logic [31:0] mcout [2];
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic r, input logic f, input logic c,
                               input logic v, input evt_t e, input logic rdy);
    rst[idx]       = r;
    flush[idx]     = f;
    clr[idx]       = c;
    in_valid[idx]  = v;
    in_evt[idx]    = e;
    out_ready[idx] = rdy;
  endtask

  task automatic idleAll();
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkOutput(input int idx);
    int sz;
    bit exp_valid;
    bit exp_ready;
    sz        = mq[idx].size();
    exp_valid = (sz > 0) && !flush[idx];
    exp_ready = (sz < depth[idx]) && !flush[idx] && !rst[idx];
    chk($sformatf("fill%0d", idx),  32'(o_fill[idx]),  32'(sz));
    chk($sformatf("full%0d", idx),  32'(o_full[idx]),  32'(sz == depth[idx]));
    chk($sformatf("empty%0d", idx), 32'(o_empty[idx]), 32'(sz == 0));
    chk($sformatf("ready%0d", idx), 32'(o_ready[idx]), 32'(exp_ready));
    chk($sformatf("valid%0d", idx), 32'(o_valid[idx]), 32'(exp_valid));
    if (exp_valid) chk($sformatf("evt%0d", idx), 32'(o_evt[idx]), 32'(mq[idx][0]));
    chk($sformatf("count_in%0d", idx),  o_cin[idx],  STATS ? mcin[idx]  : 32'd0);
    chk($sformatf("count_out%0d", idx), o_cout[idx], STATS ? mcout[idx] : 32'd0);
  endtask

  task automatic modelStep(input int idx);
    int sz;
    bit do_push;
    bit do_pop;
    sz      = mq[idx].size();
    do_push = in_valid[idx] && (sz < depth[idx]) && !flush[idx] && !rst[idx];
    do_pop  = (sz > 0) && !flush[idx] && out_ready[idx];
    if (rst[idx]) begin
      mq[idx].delete();
      mcin[idx]  = 0;
      mcout[idx] = 0;
    end else if (flush[idx]) begin
      mq[idx].delete();
      if (clr[idx]) begin
        mcin[idx]  = 0;
        mcout[idx] = 0;
      end
    end else begin
      if (do_pop) void'(mq[idx].pop_front());
      if (do_push) mq[idx].push_back(in_evt[idx]);
      if (clr[idx]) begin
        mcin[idx]  = 0;
        mcout[idx] = 0;
      end else begin
        mcin[idx]  = mcin[idx] + 32'(do_push);
        mcout[idx] = mcout[idx] + 32'(do_pop);
      end
    end
  endtask

  // Called at the negedge: compare both instances, advance the model, then
  // move to just after the next rising edge.
  task automatic commitCycle();
    if (checking) begin
      checkOutput(0);
      checkOutput(1);
    end
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    commitCycle();
  endtask

  typedef struct {
    logic v;
    evt_t e;
    logic rdy;
    logic fl;
    int   exp_fill;
    logic exp_full;
    logic exp_ready;
    logic exp_valid;
    evt_t exp_evt;
  } vec_t;

  function automatic vec_t mk(input logic v, input evt_t e, input logic rdy, input logic fl,
                              input int f, input logic fu, input logic er, input logic ev,
                              input evt_t ee);
    vec_t r;
    r.v = v; r.e = e; r.rdy = rdy; r.fl = fl;
    r.exp_fill = f; r.exp_full = fu; r.exp_ready = er; r.exp_valid = ev; r.exp_evt = ee;
    return r;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [15];
    int   outs;
    int   next_in;
    int   next_out;
    int   delivered;
    bit   accepted;

    vecs[0]  = mk(1'b1, 8'h0A, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    vecs[1]  = mk(1'b1, 8'h0B, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'h0A);
    vecs[2]  = mk(1'b1, 8'h0C, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'h0A);
    vecs[3]  = mk(1'b1, 8'h0D, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 8'h0A);
    vecs[4]  = mk(1'b1, 8'h0E, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1, 8'h0A);
    vecs[5]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1, 8'h0A);
    vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b1, 8'h0B);
    vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'h0C);
    vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'h0D);
    vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    vecs[10] = mk(1'b1, 8'h21, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    vecs[11] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'h21);
    vecs[12] = mk(1'b1, 8'h23, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 8'h21);
    vecs[13] = mk(1'b1, 8'h24, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 2; i++) begin
      mcin[i]  = 0;
      mcout[i] = 0;
    end

    // Reset: first cycle only establishes known state, second is checked.
    idleAll();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    #1;
    tick();
    checking = 1'b1;
    tick();
    idleAll();

    // Directed table on the DEPTH=4 instance: fill to full, drain, flush.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 1'b0, vecs[i].fl, 1'b0, vecs[i].v, vecs[i].e, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_fill", i),  32'(o_fill[0]),  32'(vecs[i].exp_fill));
      chk($sformatf("tbl%0d_full", i),  32'(o_full[0]),  32'(vecs[i].exp_full));
      chk($sformatf("tbl%0d_empty", i), 32'(o_empty[0]), 32'(vecs[i].exp_fill == 0));
      chk($sformatf("tbl%0d_ready", i), 32'(o_ready[0]), 32'(vecs[i].exp_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid[0]), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("tbl%0d_evt", i), 32'(o_evt[0]), 32'(vecs[i].exp_evt));
      commitCycle();
    end

    // Clear the counters, then stream 100 cycles at full rate.
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    outs = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(i + 16), 1'b1);
      @(negedge clk);
      if (i > 0) begin
        chk("stream_fill", 32'(o_fill[0]), 32'd1);
        chk("stream_valid", 32'(o_valid[0]), 32'd1);
        if (STATS) chk("stream_diff", o_cin[0] - o_cout[0], 32'(o_fill[0]));
        else chk("stream_cnt", o_cin[0] | o_cout[0], 32'd0);
      end
      if (o_valid[0] && out_ready[0]) outs++;
      commitCycle();
    end
    chk("stream_outs", 32'(outs), 32'd99);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    tick();

    // Reset with two events stored.
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h51, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h52, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_fill", 32'(o_fill[0]), 32'd0);
    chk("rst_cin", o_cin[0], 32'd0);
    chk("rst_cout", o_cout[0], 32'd0);
    commitCycle();

    // Clear coinciding with an accepted input.
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h61, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h62, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("clr_cin", o_cin[0], 32'd0);
    chk("clr_fill", 32'(o_fill[0]), 32'd2);
    commitCycle();
    idleAll();

    // DEPTH=3 wrap-around: 10 numbered events, random interleaving.
    next_in   = 0;
    next_out  = 0;
    delivered = 0;
    for (int c = 0; c < 300 && delivered < 10; c++) begin
      applyStimulus(1, 1'b0, 1'b0, 1'b0, (next_in < 10) && ($urandom_range(1) == 1),
                    8'(next_in), $urandom_range(1) == 1);
      @(negedge clk);
      if (o_valid[1] && out_ready[1]) begin
        chk("wrap_order", 32'(o_evt[1]), 32'(next_out));
        next_out++;
        delivered++;
      end
      accepted = in_valid[1] && (mq[1].size() < depth[1]);
      if (accepted) next_in++;
      commitCycle();
    end
    chk("wrap_count", 32'(delivered), 32'd10);
    idleAll();

    // Random soak on both instances including flush, clear and reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        applyStimulus(i, $urandom_range(63) == 0, $urandom_range(15) == 0,
                      $urandom_range(31) == 0, $urandom_range(1) == 1,
                      8'($urandom), $urandom_range(3) != 0);
      end
      tick();
    end
    idleAll();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
